// File: rtl/pulse_event_arbiter.sv
// Pulse event arbiter: synchronizes NUM_CH noisy inputs, counts rising edges
// per channel and drains them round-robin onto one valid/ready event port.
module pulse_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] noisy_in,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              ovf_clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic [NUM_CH-1:0] ovf,
  output logic              busy
);

  typedef enum logic {EMPTY, OFFER} state_e;

  state_e state_q, state_d;

  logic [NUM_CH-1:0] s0_q, s1_q, s2_q;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  logic [NUM_CH-1:0] rise, elig, dec, ovf_set;
  logic [CH_W-1:0]   grant;
  logic [CH_W:0]     scan;
  logic              found, load, pend;

  always_comb begin
    rise = s1_q & ~s2_q & ch_en;
    pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = (cnt_q[i] != '0) & ch_en[i];
      pend = pend | (cnt_q[i] != '0);
    end

    found = 1'b0;
    grant = '0;
    scan = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan = {1'b0, rr_q} + (CH_W+1)'(k);
      if (scan >= (CH_W+1)'(NUM_CH))
        scan = scan - (CH_W+1)'(NUM_CH);
      if (!found && elig[scan[CH_W-1:0]]) begin
        found = 1'b1;
        grant = scan[CH_W-1:0];
      end
    end

    load = ((state_q == EMPTY) || evt_ready) && found;

    state_d = state_q;
    ch_d = ch_q;
    rr_d = rr_q;
    if (load) begin
      state_d = OFFER;
      ch_d = grant;
      rr_d = (grant == CH_W'(NUM_CH-1)) ? '0
           : grant + CH_W'(1);
    end else if (state_q == OFFER && evt_ready) begin
      state_d = EMPTY;
    end

    // Saturated counters drop the edge and flag it sticky
    ovf_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dec[i] = load && (grant == CH_W'(i));
      cnt_d[i] = cnt_q[i];
      unique case (1'b1)
        rise[i] & ~dec[i]: begin
          if (cnt_q[i] == {CNT_W{1'b1}})
            ovf_set[i] = 1'b1;
          else
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        dec[i] & ~rise[i]:
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: ;
      endcase
    end

    ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= '0;
      rr_q <= '0;
      ch_q <= '0;
      ovf_q <= '0;
      state_q <= EMPTY;
    end else begin
      s0_q <= noisy_in;
      s1_q <= s0_q;
      s2_q <= s1_q;
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= cnt_d[i];
      rr_q <= rr_d;
      ch_q <= ch_d;
      ovf_q <= ovf_d;
      state_q <= state_d;
    end
  end

  assign evt_valid = (state_q == OFFER);
  assign evt_ch = ch_q;
  assign ovf = ovf_q;
  assign busy = evt_valid | pend;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Bench for pulse_event_arbiter: cycle model built from an input-history
// queue and per-channel integer counts, plus directed expectations.
module tb_pulse_event_arbiter;

  localparam int NUM_CH = 4;
  localparam int CNT_W = 4;
  localparam int MAXC = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] noisy_in = '0;
  logic [3:0] ch_en = 4'hF;
  logic ovf_clr = 1'b0;
  logic evt_ready = 1'b0;
  logic evt_valid;
  logic [1:0] evt_ch;
  logic [3:0] ovf;
  logic busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_q[$];

  // reference model state
  logic [3:0] hist [3];
  int m_cnt [NUM_CH];
  int m_rr;
  bit m_valid;
  int m_ch;
  logic [3:0] m_ovf;

  pulse_event_arbiter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .noisy_in(noisy_in), .ch_en(ch_en),
    .ovf_clr(ovf_clr), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mvec();
    bit b;
    b = m_valid;
    for (int c = 0; c < NUM_CH; c++)
      if (m_cnt[c] != 0) b = 1'b1;
    return {m_valid, 2'(m_ch), m_ovf, b};
  endfunction

  function automatic logic [7:0] dvec();
    return {evt_valid, evt_ch, ovf, busy};
  endfunction

  task automatic model_step();
    logic [3:0] r;
    logic [3:0] onext;
    int g;
    bit ld;
    if (rst) begin
      for (int k = 0; k < 3; k++) hist[k] = '0;
      for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
      m_rr = 0; m_valid = 0; m_ch = 0; m_ovf = '0;
      return;
    end
    // an edge is a 0 then 1 seen two and three samples back
    r = hist[1] & ~hist[2] & ch_en;
    g = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_rr + k) % NUM_CH;
      if (g < 0 && m_cnt[c] > 0 && ch_en[c]) g = c;
    end
    ld = (!m_valid || evt_ready) && g >= 0;
    onext = ovf_clr ? 4'h0 : m_ovf;
    for (int c = 0; c < NUM_CH; c++) begin
      bit d;
      d = ld && g == c;
      if (r[c] && !d) begin
        if (m_cnt[c] == MAXC) onext[c] = 1'b1;
        else m_cnt[c]++;
      end else if (d && !r[c]) begin
        m_cnt[c]--;
      end
    end
    m_ovf = onext;
    if (ld) begin
      m_valid = 1; m_ch = g; m_rr = (g + 1) % NUM_CH;
    end else if (m_valid && evt_ready) begin
      m_valid = 0;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = noisy_in;
  endtask

  task automatic tick();
    if (evt_valid === 1'b1 && evt_ready === 1'b1)
      acc_q.push_back(int'(evt_ch));
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (dvec() !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state cyc=%0d got=%h want=00", cyc, dvec());
    end
    vectors++;
    if (dvec() !== mvec()) begin
      miscompares++;
      $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, dvec(), mvec());
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int first;
    first = -1;
    acc_q.delete();
    evt_ready = 1'b1;
    noisy_in = 4'b0001;
    for (int t = 1; t <= 8; t++) begin
      tick();
      vectors++;
      if (dvec() !== mvec()) begin
        miscompares++;
        $display("FAIL latency_model cyc=%0d got=%h want=%h", cyc, dvec(), mvec());
      end
      if (first < 0 && evt_valid === 1'b1) first = t;
    end
    vectors++;
    if (first !== 4) begin
      miscompares++;
      $display("FAIL latency_first_valid got edge %0d want edge 4", first);
    end
    vectors++;
    if (acc_q.size() !== 1 || acc_q[0] !== 0) begin
      miscompares++;
      $display("FAIL latency_events got %0d events want 1 on ch0", acc_q.size());
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_idle busy got %b want 0", busy);
    end
    noisy_in = '0;
  endtask

  task automatic test_round_robin();
    int exp_seq [6];
    exp_seq = '{0, 1, 2, 3, 1, 3};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_q.delete();
    evt_ready = 1'b1;
    for (int t = 0; t < 24; t++) begin
      noisy_in = (t < 8) ? 4'hF : (t < 12) ? 4'h0 : (t < 20) ? 4'hA : 4'h0;
      tick();
      vectors++;
      if (dvec() !== mvec()) begin
        miscompares++;
        $display("FAIL rr_model cyc=%0d got=%h want=%h", cyc, dvec(), mvec());
      end
    end
    vectors++;
    if (acc_q.size() !== 6) begin
      miscompares++;
      $display("FAIL rr_count got %0d want 6", acc_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (acc_q[i] !== exp_seq[i]) begin
          miscompares++;
          $display("FAIL rr_order[%0d] got %0d want %0d", i, acc_q[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int n2;
    acc_q.delete();
    evt_ready = 1'b0;
    for (int t = 0; t < 40; t++) begin
      noisy_in = (t < 34 && t % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
      vectors++;
      if (dvec() !== mvec()) begin
        miscompares++;
        $display("FAIL ovf_model cyc=%0d got=%h want=%h", cyc, dvec(), mvec());
      end
    end
    vectors++;
    if (ovf !== 4'b0100 || evt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set ovf=%b valid=%b want 0100/1", ovf, evt_valid);
    end
    evt_ready = 1'b1;
    for (int t = 0; t < 22; t++) begin
      tick();
      vectors++;
      if (dvec() !== mvec()) begin
        miscompares++;
        $display("FAIL ovf_drain_model cyc=%0d got=%h want=%h", cyc, dvec(), mvec());
      end
    end
    n2 = 0;
    foreach (acc_q[i]) if (acc_q[i] == 2) n2++;
    // one event already held in the output stage plus 15 queued
    vectors++;
    if (n2 !== 16 || acc_q.size() !== 16) begin
      miscompares++;
      $display("FAIL ovf_drain got %0d ch2 of %0d want 16", n2, acc_q.size());
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    vectors++;
    if (ovf !== 4'b0000 || dvec() !== mvec()) begin
      miscompares++;
      $display("FAIL ovf_clear ovf=%b want 0000", ovf);
    end
  endtask

  task automatic test_hold();
    evt_ready = 1'b0;
    for (int t = 0; t < 10; t++) begin
      noisy_in = (t == 0) ? 4'b0011 : 4'b0000;
      tick();
      vectors++;
      if (dvec() !== mvec()) begin
        miscompares++;
        $display("FAIL hold_model cyc=%0d got=%h want=%h", cyc, dvec(), mvec());
      end
    end
    for (int t = 0; t < 5; t++) begin
      tick();
      vectors++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin
        miscompares++;
        $display("FAIL hold_stable valid=%b ch=%0d want 1/0", evt_valid, evt_ch);
      end
    end
    evt_ready = 1'b1;
    tick();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin
      miscompares++;
      $display("FAIL hold_next valid=%b ch=%0d want 1/1", evt_valid, evt_ch);
    end
    for (int t = 0; t < 3; t++) tick();
  endtask

  task automatic test_enable();
    acc_q.delete();
    evt_ready = 1'b1;
    ch_en = 4'b1101;
    for (int t = 0; t < 8; t++) begin
      noisy_in = (t == 0) ? 4'b0010 : 4'b0000;
      tick();
      vectors++;
      if (dvec() !== mvec()) begin
        miscompares++;
        $display("FAIL en_model cyc=%0d got=%h want=%h", cyc, dvec(), mvec());
      end
    end
    vectors++;
    if (acc_q.size() !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL en_ignore got %0d events busy=%b want 0/0", acc_q.size(), busy);
    end
    evt_ready = 1'b0;
    ch_en = 4'hF;
    for (int t = 0; t < 12; t++) begin
      noisy_in = (t < 6 && t % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
    end
    ch_en = 4'b1101;
    evt_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      vectors++;
      if (dvec() !== mvec()) begin
        miscompares++;
        $display("FAIL en_off_model cyc=%0d got=%h want=%h", cyc, dvec(), mvec());
      end
    end
    vectors++;
    if (acc_q.size() !== 1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL en_block got %0d events busy=%b want 1/1", acc_q.size(), busy);
    end
    ch_en = 4'hF;
    for (int t = 0; t < 6; t++) tick();
    vectors++;
    if (acc_q.size() !== 3 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL en_resume got %0d events busy=%b want 3/0", acc_q.size(), busy);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      noisy_in = 4'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      ch_en = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
      vectors++;
      if (dvec() !== mvec()) begin
        miscompares++;
        $display("FAIL rand_model cyc=%0d got=%h want=%h", cyc, dvec(), mvec());
      end
    end
    ovf_clr = 1'b0;
    ch_en = 4'hF;
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    for (int t = 0; t < 10; t++) begin
      noisy_in = {1'b1, (t < 6 && t % 2 == 0) ? 3'b111 : 3'b000};
      tick();
    end
    vectors++;
    if (evt_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre valid=%b busy=%b want 1/1", evt_valid, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (dvec() !== 8'h00) begin
      miscompares++;
      $display("FAIL rstmid_clear got=%h want=00", dvec());
    end
    acc_q.delete();
    evt_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      vectors++;
      if (dvec() !== mvec()) begin
        miscompares++;
        $display("FAIL rstmid_model cyc=%0d got=%h want=%h", cyc, dvec(), mvec());
      end
    end
    vectors++;
    if (acc_q.size() !== 1 || acc_q[0] !== 3) begin
      miscompares++;
      $display("FAIL rstmid_events got %0d events want exactly one on ch3", acc_q.size());
    end
    noisy_in = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_hold();
    test_enable();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
